fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Front-end fetch stage of the single-cycle core. It sits directly upstream of the instruction memory and drives its request and word address.
- The instruction memory returns data combinationally in the same cycle. The fetch stage captures each instruction with its PC into a small FIFO and presents it to decode over a valid/ready handshake.
- It handles sequential PC increment, redirects (branch/jump), flush, and sticky fault detection for misaligned or out-of-range PCs.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words. Legal byte addresses are 0 .. IMEM_WORDS*4-4.
- BUF_DEPTH, 2, fetch buffer entries. Must be 2 or more.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- instr_mem_req_o  output  1  fetch request to instruction memory.
- instr_mem_addr_o  output  32  byte address to instruction memory; always equals the current PC.
- instr_mem_data_i  input  32  instruction returned in the same cycle as the request.
- redirect_valid_i  input  1  redirect PC (taken branch/jump) and flush the buffer.
- redirect_pc_i  input  32  redirect target, byte address.
- fetch_valid_o  output  1  buffer head valid toward decode.
- fetch_instr_o  output  32  head instruction.
- fetch_pc_o  output  32  PC of head instruction.
- fetch_ready_i  input  1  decode accepts head.
- fault_o  output  1  sticky fetch fault.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, sampled only on the rising edge of clk.
- State machine, encoded in 2 bits: RUN, FAULT.
- Reset sets:
  - state=RUN, pc=RESET_PC, buffer count=0.
  - fault_o=0, fetch_valid_o=0, instr_mem_req_o=0.
  - fetch_instr_o and fetch_pc_o = 0 while invalid.
- instr_mem_req_o is combinational. It is 1 only when all of the following hold: state=RUN, reset=0, redirect_valid_i=0, count<BUF_DEPTH, pc legal.
- A PC is legal when pc[1:0]=0 and pc < IMEM_WORDS*4.
- Push: on any cycle with instr_mem_req_o=1:
  - {pc, instr_mem_data_i} is written to the buffer tail.
  - pc <= pc+4, with 32-bit wrap, no carry.
- Pop: fires when fetch_valid_o && fetch_ready_i; the head advances.
- Push and pop can occur in the same cycle, and count is unchanged. At BUF_DEPTH=2 this gives one instruction per cycle sustained throughput.
- fetch_valid_o = (count!=0). The head data is stable while valid && !ready.
- Full buffer (count=BUF_DEPTH): no request is issued and pc holds. A pop in that cycle does not enable a same-cycle push; the request resumes next cycle.
- Empty buffer: fetch_valid_o=0. There is no combinational bypass from memory to decode, so there is 1 cycle of latency from request to fetch_valid_o.
- Redirect (redirect_valid_i=1, state=RUN):
  - Buffer is flushed (count<=0) and pc<=redirect_pc_i.
  - No request that cycle; any pop that cycle is discarded (the decoder ignores it).
  - The first new request comes the cycle after the redirect.
- Redirect has priority over push and pop.
- Back-to-back redirects: the last one wins.
- Fault: if state=RUN and the current pc is illegal while the buffer has space and there is no redirect:
  - state <= FAULT, fault_o <= 1.
  - No request is made for that pc.
- An illegal PC is also detected after a sequential increment past the top of memory.
- In FAULT:
  - instr_mem_req_o=0 and redirects are ignored.
  - Already-buffered entries still drain to decode.
  - Only reset leaves FAULT.
- Reset mid-operation: the buffer contents are discarded immediately. Outputs take their reset values on the next edge, and no request is issued in the reset cycle.

Test Plan:
- Reset release with RESET_PC=0, memory word i = 32'h1000_0000+i, fetch_ready_i=1:
  - req=1 with addr 0,4,8,... on consecutive cycles.
  - fetch_valid_o from cycle 2, with pc/instr pairs (0,0x10000000), (4,0x10000001) and so on, one per cycle, no bubbles.
- Backpressure: fetch_ready_i=0 for 5 cycles after the first request.
  - Exactly 2 requests (addr 0, 4), then req=0.
  - Head holds pc=0 stable.
  - On ready=1, drains pc 0, 4, 8 in order with no loss or duplicate.
- Redirect to 0x100 while count=2:
  - req=0 that cycle, fetch_valid_o=0 next cycle.
  - Next request addr=0x100, and the next delivered pc=0x100.
- Simultaneous redirect and pop: the redirect wins, the buffer empties, and only post-redirect PCs appear.
- Misaligned redirect to 0x102:
  - Next cycle, fault_o=1 and req=0 permanently.
  - A further redirect to 0x200 is ignored.
  - Reset clears fault_o.
- Fetch to top of memory with IMEM_WORDS=4 from pc=0:
  - Requests at 0, 4, 8, 12, then fault_o=1 when pc=16.
  - The four buffered instructions all still drain to decode.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: walks the PC, requests words from a combinational instruction memory,
// and queues {pc, instr} pairs toward decode. A sticky fault parks the stage until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        instr_mem_req_o,
    output logic [31:0] instr_mem_addr_o,
    input  logic [31:0] instr_mem_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    input  logic        fetch_ready_i,
    output logic        fault_o
);
    localparam int          PW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int          CW    = $clog2(BUF_DEPTH + 1);
    localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FAULT = 2'd1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   r_buf_pc    [BUF_DEPTH];
    logic [31:0]   r_buf_instr [BUF_DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;

    logic w_legal, w_space, w_req, w_pop, w_redirect;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // 33-bit compare so a PC just past the top of memory is caught even at full address range
    assign w_legal    = (r_pc[1:0] == 2'b00) && ({1'b0, r_pc} < LIMIT);
    assign w_space    = (r_count < CW'(BUF_DEPTH));
    assign w_redirect = redirect_valid_i && (r_state == S_RUN);
    assign w_pop      = fetch_valid_o && fetch_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            S_RUN: begin
                if (!redirect_valid_i && w_space) begin
                    if (w_legal) w_req = !reset;
                    else         w_state_nxt = S_FAULT;
                end
            end
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_redirect) begin
                // flush wins over any same-cycle push or pop
                r_pc    <= redirect_pc_i;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_req) begin
                    r_tail <= ptr_inc(r_tail);
                    r_pc   <= r_pc + 32'd4;
                end
                if (w_pop) r_head <= ptr_inc(r_head);
                r_count <= r_count + CW'(w_req) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req && !w_redirect) begin
            r_buf_pc[r_tail]    <= r_pc;
            r_buf_instr[r_tail] <= instr_mem_data_i;
        end
    end

    assign instr_mem_req_o  = w_req;
    assign instr_mem_addr_o = r_pc;
    assign fetch_valid_o    = (r_count != '0);
    assign fetch_pc_o       = fetch_valid_o ? r_buf_pc[r_head]    : 32'd0;
    assign fetch_instr_o    = fetch_valid_o ? r_buf_instr[r_head] : 32'd0;
    assign fault_o          = (r_state == S_FAULT);
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps plus random traffic, compared cycle by cycle
// against a queue-based model. A second instance with a 4-word memory covers the top-of-memory case.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, redir, rdy;
    logic [31:0] rpc;
    bit          sel;

    logic        req0, val0, flt0, req1, val1, flt1;
    logic [31:0] addr0, data0, ins0, pc0, addr1, data1, ins1, pc1;

    always #5 clk = ~clk;

    assign data0 = 32'h1000_0000 + {2'b00, addr0[31:2]};
    assign data1 = 32'h1000_0000 + {2'b00, addr1[31:2]};

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(1024), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst),
        .instr_mem_req_o(req0), .instr_mem_addr_o(addr0), .instr_mem_data_i(data0),
        .redirect_valid_i(redir), .redirect_pc_i(rpc),
        .fetch_valid_o(val0), .fetch_instr_o(ins0), .fetch_pc_o(pc0),
        .fetch_ready_i(rdy), .fault_o(flt0)
    );

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4), .BUF_DEPTH(DEPTH)) dut_small (
        .clk(clk), .reset(rst),
        .instr_mem_req_o(req1), .instr_mem_addr_o(addr1), .instr_mem_data_i(data1),
        .redirect_valid_i(redir), .redirect_pc_i(rpc),
        .fetch_valid_o(val1), .fetch_instr_o(ins1), .fetch_pc_o(pc1),
        .fetch_ready_i(rdy), .fault_o(flt1)
    );

    // reference model state
    logic [31:0] m_pc;
    bit          m_fault;
    logic [63:0] q[$];
    int unsigned limit;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit rv, input logic [31:0] rp, input bit rd, input bit do_chk = 1'b1);
        bit legal, space, e_req, e_val;
        logic [31:0] e_pc, e_ins;
        rst = r; redir = rv; rpc = rp; rdy = rd;
        #1;
        legal = (m_pc[1:0] == 2'b00) && ({32'd0, m_pc} < 64'(limit));
        space = q.size() < DEPTH;
        e_req = !r && !m_fault && !rv && space && legal;
        e_val = q.size() != 0;
        e_pc  = e_val ? q[0][63:32] : 32'd0;
        e_ins = e_val ? q[0][31:0]  : 32'd0;
        if (do_chk) begin
            chk("req",   32'(sel ? req1 : req0), 32'(e_req));
            chk("addr",  sel ? addr1 : addr0, m_pc);
            chk("valid", 32'(sel ? val1 : val0), 32'(e_val));
            chk("pc",    sel ? pc1 : pc0, e_pc);
            chk("instr", sel ? ins1 : ins0, e_ins);
            chk("fault", 32'(sel ? flt1 : flt0), 32'(m_fault));
        end
        @(posedge clk);
        if (r) begin
            q.delete(); m_pc = 32'h0; m_fault = 1'b0;
        end else if (!m_fault && rv) begin
            q.delete(); m_pc = rp;
        end else begin
            if (e_val && rd) void'(q.pop_front());
            if (e_req) begin
                q.push_back({m_pc, mem(m_pc)});
                m_pc = m_pc + 32'd4;
            end else if (!m_fault && space && !legal) begin
                m_fault = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_run(input int n);
        bit r, rv, rd;
        logic [31:0] rp;
        int k;
        for (int i = 0; i < n; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            rv = ($urandom_range(0, 11) == 0);
            rd = ($urandom_range(0, 3) != 0);
            k  = int'($urandom_range(0, 9));
            if (k < 7)       rp = 32'($urandom_range(0, limit / 4 - 1)) * 32'd4;
            else if (k == 7) rp = limit - 32'd8;
            else if (k == 8) rp = limit - 32'd8 + 32'd2;
            else             rp = limit + 32'($urandom_range(0, 4)) * 32'd4;
            cyc(r, rv, rp, rd);
        end
    endtask

    initial begin
        sel = 1'b0; limit = 1024 * 4;
        m_pc = 32'h0; m_fault = 1'b0;
        // first reset edge brings the DUT out of X; nothing to compare before it
        cyc(1, 0, 0, 1, 1'b0);
        cyc(1, 0, 0, 1);

        // streaming from reset, one instruction per cycle
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);

        // backpressure: two requests then stall, drain in order
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);

        // redirect while full
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h100, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

        // redirect coinciding with a pop, then back-to-back redirects
        cyc(0, 1, 32'h40, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h300, 1);
        cyc(0, 1, 32'h380, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

        // misaligned redirect faults; later redirect ignored; reset clears
        cyc(0, 1, 32'h102, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h200, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

        // sequential walk off the top of memory
        cyc(0, 1, 32'hFF8, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);

        rand_run(400);

        // 4-word memory instance
        sel = 1'b1; limit = 4 * 4;
        cyc(1, 0, 0, 0, 1'b0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);

        rand_run(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
